wb_regfile: RTL

Write-back stage for the five-stage MIPS core: consumes the memory stage's register-write and HI/LO-write outputs, registers them in the MEM/WB pipeline latch, and commits them one cycle later into the 32×32 general-purpose register file and the HI/LO pair. It also serves the decode stage's two GPR read ports and the execute stage's HI/LO read, with write-through bypass so that a value being committed is visible to readers in the same cycle.

---
 rtl/wb_regfile.sv | 131 +++++++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// MEM/WB pipeline latch plus the 32x32 GPR file and HI/LO pair of the MIPS core.
// The latched entry commits one edge later and is bypassed to every reader meanwhile.
module wb_regfile_rdport (
    input  logic             rst_i,
    input  logic [4:0]       raddr_i,
    input  logic             wb_write_i,
    input  logic [4:0]       wb_addr_i,
    input  logic [31:0]      wb_data_i,
    input  logic [31:0][31:0] regs_i,
    output logic [31:0]      rdata_o
);
    always_comb begin
        rdata_o = '0;
        if (!rst_i && raddr_i != 5'd0) begin
            // Address match with a nonzero raddr also rules out a bypassed r0 write.
            if (wb_write_i && wb_addr_i == raddr_i) rdata_o = wb_data_i;
            else                                    rdata_o = regs_i[raddr_i];
        end
    end
endmodule

module wb_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        wreg_write_i,
    input  logic [4:0]  wreg_addr_i,
    input  logic [31:0] wreg_data_i,
    input  logic        whilo_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        wb_wreg_write_o,
    output logic [4:0]  wb_wreg_addr_o,
    output logic [31:0] wb_wreg_data_o
);
    localparam int NUM_RPORTS = 2;

    logic        wb_write_q, wb_write_d;
    logic [4:0]  wb_addr_q,  wb_addr_d;
    logic [31:0] wb_data_q,  wb_data_d;
    logic        wb_whilo_q, wb_whilo_d;
    logic [31:0] wb_hi_q,    wb_hi_d;
    logic [31:0] wb_lo_q,    wb_lo_d;

    // Entry 0 is never written, so it stays zero after reset.
    logic [31:0][31:0] regs_q;
    logic [31:0]       hi_q, lo_q;

    always_comb begin
        wb_write_d = wreg_write_i;
        wb_addr_d  = wreg_addr_i;
        wb_data_d  = wreg_data_i;
        wb_whilo_d = whilo_i;
        wb_hi_d    = hi_i;
        wb_lo_d    = lo_i;
        if (flush_i || stall_i) begin
            wb_write_d = 1'b0;
            wb_addr_d  = '0;
            wb_data_d  = '0;
            wb_whilo_d = 1'b0;
            wb_hi_d    = '0;
            wb_lo_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_write_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_whilo_q <= 1'b0;
            wb_hi_q    <= '0;
            wb_lo_q    <= '0;
            regs_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            wb_write_q <= wb_write_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            wb_whilo_q <= wb_whilo_d;
            wb_hi_q    <= wb_hi_d;
            wb_lo_q    <= wb_lo_d;
            if (wb_write_q && wb_addr_q != 5'd0) regs_q[wb_addr_q] <= wb_data_q;
            if (wb_whilo_q) begin
                hi_q <= wb_hi_q;
                lo_q <= wb_lo_q;
            end
        end
    end

    logic [NUM_RPORTS-1:0][4:0]  raddr;
    logic [NUM_RPORTS-1:0][31:0] rdata;

    assign raddr = {raddr2_i, raddr1_i};

    for (genvar g = 0; g < NUM_RPORTS; g++) begin : g_rport
        wb_regfile_rdport u_rdport (
            .rst_i      (rst),
            .raddr_i    (raddr[g]),
            .wb_write_i (wb_write_q),
            .wb_addr_i  (wb_addr_q),
            .wb_data_i  (wb_data_q),
            .regs_i     (regs_q),
            .rdata_o    (rdata[g])
        );
    end

    assign rdata1_o = rdata[0];
    assign rdata2_o = rdata[1];

    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (!rst) begin
            hi_o = wb_whilo_q ? wb_hi_q : hi_q;
            lo_o = wb_whilo_q ? wb_lo_q : lo_q;
        end
    end

    assign wb_wreg_write_o = rst ? 1'b0 : wb_write_q;
    assign wb_wreg_addr_o  = rst ? 5'd0 : wb_addr_q;
    assign wb_wreg_data_o  = rst ? 32'd0 : wb_data_q;
endmodule
